// File: rtl/one_port_ram_ctrl.sv
// one_port_ram_ctrl: requester-side controller for a single-port RAM with a
// registered address. A valid/ready request stream (read or write) is turned
// into RAM port activity. Read data returns on a valid/ready response channel
// with a two-cycle latency, and only one read is outstanding at a time.
//
// Optional feature macro: RAM_CTRL_CLEAR_ON_RESET_EN
//   When it is defined, every address is written with zero after reset (one
//   address per cycle) before requests are accepted. While the sweep runs,
//   busy is high.
//
// Ports:
//   clk, rst         single clock; synchronous active-high reset
//   req_valid/ready  request handshake; req_we=1 write, 0 read
//   req_addr/data    request address and write data
//   rsp_valid/ready  read response handshake
//   rsp_data/addr    read data and the address it came from
//   busy             clear sweep in progress (tied 0 without the feature)
//   ram_*            connection to the RAM (data_in, addr, we / data_out, addr_out)
module one_port_ram_ctrl #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic [ADDR_WIDTH-1:0] ram_addr_out
);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } state_t;

`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
  localparam state_t                  RST_STATE = ST_CLEAR;
  localparam logic [ADDR_WIDTH-1:0]   CNT_LAST  = '1;
  logic [ADDR_WIDTH-1:0] clr_cnt;
`else
  localparam state_t                  RST_STATE = ST_IDLE;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  accept;

  // Requests are only taken in IDLE; reset blocks acceptance in the same cycle.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
  assign busy = (state == ST_CLEAR) && !rst;
`else
  assign busy = 1'b0;
`endif

  // RAM port drive: request passes straight through in IDLE so a write lands
  // on the accept edge; RD_WAIT keeps the read address on the port.
  always_comb begin
    ram_addr    = req_addr;
    ram_data_in = req_data;
    ram_we      = 1'b0;
    case (state)
      ST_IDLE:    ram_we = accept && req_we;
      ST_RD_WAIT: ram_addr = rd_addr;
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        ram_addr    = clr_cnt;
        ram_data_in = '0;
        ram_we      = !rst;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM and registered response channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
      clr_cnt   <= '0;
`endif
    end else begin
      case (state)
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == CNT_LAST) state <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (accept && !req_we) begin
            rd_addr <= req_addr;
            state   <= ST_RD_WAIT;
          end
        end
        // RAM output is valid this cycle for the address latched on accept.
        ST_RD_WAIT: begin
          rsp_data  <= ram_data_out;
          rsp_addr  <= ram_addr_out;
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_port_ram_ctrl.sv
// Bench for one_port_ram_ctrl: controller wired to a registered-address RAM
// model, directed scenarios plus a random read/write mix against a shadow memory.
module tb_one_port_ram_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          busy;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data_out;
  logic [AW-1:0] ram_addr_out;

  int n_cmp;
  int n_err;

  logic [DW-1:0] exp_mem [64];

  one_port_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_addr     (rsp_addr),
    .busy         (busy),
    .ram_data_in  (ram_data_in),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out),
    .ram_addr_out (ram_addr_out)
  );

  // RAM model: write on the edge, address registered, data out from the latched address.
  logic [DW-1:0] mem [64];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_addr_q <= ram_addr;
  end
  assign ram_data_out = mem[ram_addr_q];
  assign ram_addr_out = ram_addr_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ram_we may only be high for an accepted write or during the clear sweep.
  always begin
    @(negedge clk);
    #2;
    n_cmp++;
    if (ram_we === 1'b1 && (rst || !((req_valid && req_ready && req_we) || busy))) begin
      n_err++;
      $display("FAIL ram_we_guard: got ram_we=1 expected 0 at %0t", $time);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
    exp_mem[a] = d;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready@%0d: got %b expected 1", a, req_ready); end
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %b expected 1", name, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s_early: got rsp_valid=%b expected 0", name, rsp_valid); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %b expected 1", name, rsp_valid); end
    n_cmp++;
    if (rsp_data !== d) begin n_err++; $display("FAIL %s_data: got %0h expected %0h", name, rsp_data, d); end
    n_cmp++;
    if (rsp_addr !== a) begin n_err++; $display("FAIL %s_addr: got %0d expected %0d", name, rsp_addr, a); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_done: got valid=%b ready=%b expected 0/1", name, rsp_valid, req_ready);
    end
  endtask

  // Wait for any clear sweep to end; shadow memory then matches the RAM state.
  task automatic after_reset;
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
    int c;
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      @(negedge clk); #1; c++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_timeout: got busy=%b expected 0", busy); end
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd3; req_data = 4'd9; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    n_cmp++;
    if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b expected 0", ram_we); end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_data !== 4'h0 || rsp_addr !== 6'd0) begin
      n_err++; $display("FAIL rst_rsp: got v=%b d=%0h a=%0d expected 0/0/0", rsp_valid, rsp_data, rsp_addr);
    end
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b expected 1", busy); end
`else
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_idle: got busy=%b ready=%b expected 0/1", busy, req_ready);
    end
`endif
    after_reset();
  endtask

  task automatic test_raw;
    wr(6'd5, 4'hA);
    rd_check("raw5", 6'd5, 4'hA);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) wr(6'(i), 4'(i));
    rd_check("b2b63", 6'd63, 4'hF);
    rd_check("b2b16", 6'd16, 4'h0);
  endtask

  task automatic test_stall;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5; rsp_ready = 1'b0;
    @(negedge clk);
    // Offer a write during the stall; it must not reach the RAM.
    req_we = 1'b1; req_addr = 6'd9; req_data = 4'h3;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'h5 || rsp_addr !== 6'd5) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b d=%0h a=%0d expected 1/5/5", k, rsp_valid, rsp_data, rsp_addr);
      end
      n_cmp++;
      if (req_ready !== 1'b0 || ram_we !== 1'b0) begin
        n_err++; $display("FAIL stall_block%0d: got ready=%b we=%b expected 0/0", k, req_ready, ram_we);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_release: got v=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_rd_wait;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd10; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_data !== 4'h0 || rsp_addr !== 6'd0) begin
        n_err++; $display("FAIL rdwait_rst%0d: got v=%b d=%0h a=%0d expected 0/0/0", k, rsp_valid, rsp_data, rsp_addr);
      end
      @(negedge clk);
    end
`ifndef RAM_CTRL_CLEAR_ON_RESET_EN
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL rdwait_idle: got ready=%b expected 1", req_ready); end
`endif
    after_reset();
  endtask

  task automatic test_clear;
    int c;
    for (int i = 0; i < 64; i++) wr(6'(i), 4'h7);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef RAM_CTRL_CLEAR_ON_RESET_EN
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      n_cmp++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready%0d: got %b expected 0", c, req_ready); end
      c++;
      @(negedge clk); #1;
    end
    n_cmp++;
    if (c != 64) begin n_err++; $display("FAIL clr_len: got %0d expected 64", c); end
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    rd_check("clr0", 6'd0, 4'h0);
    rd_check("clr31", 6'd31, 4'h0);
    rd_check("clr63", 6'd63, 4'h0);
`else
    c = 0;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL noclr_idle: got busy=%b ready=%b expected 0/1", busy, req_ready);
    end
    rd_check("keep31", 6'd31, 4'h7);
`endif
  endtask

  task automatic test_random;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit got;
    for (int op = 0; op < 120; op++) begin
      a = 6'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wr(a, d);
      end else begin
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready%0d: got %b expected 1", op, req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          #1;
          if (rsp_valid === 1'b1 && rsp_ready) begin
            got = 1'b1;
            n_cmp++;
            if (rsp_data !== exp_mem[a] || rsp_addr !== a) begin
              n_err++; $display("FAIL rnd_rsp%0d: got d=%0h a=%0d expected d=%0h a=%0d", op, rsp_data, rsp_addr, exp_mem[a], a);
            end
          end
          @(negedge clk);
        end
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL rnd_timeout%0d: got no response expected one", op); end
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_raw();
    test_back_to_back();
    test_stall();
    test_reset_in_rd_wait();
    test_clear();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
